// File: rtl/udp_tx_framer.sv
// UDP transmit framer: packs application bytes plus a 3-word header into a word buffer, then hands it to the core.
// Optional macro UDP_TX_FRAMER_CNT_EN adds the released-datagram counter on tx_frame_count.
module udp_tx_framer #(
  parameter int AWIDTH = 6
) (
  input  logic              clk_int,
  input  logic              rst_n,
  input  logic              app_valid,
  output logic              app_ready,
  input  logic [7:0]        app_data,
  input  logic              app_last,
  input  logic [31:0]       app_dst_ip,
  input  logic [15:0]       app_src_port,
  input  logic [15:0]       app_dst_port,
  output logic              tx_trunc,
  output logic              udp_txbuf_rel,
  input  logic              udp_txbuf_grant,
  input  logic [AWIDTH-1:0] udp_txbuf_addr,
  input  logic              udp_txbuf_ce,
  output logic [31:0]       udp_txbuf_rdata,
  output logic [15:0]       tx_frame_count
);
  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [15:0] MAXB = 16'(4 * (DEPTH - 3));

  typedef enum logic [2:0] {IDLE, FILL, HDR, REL, BUSY} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_live;
  logic [15:0]       r_cnt;
  logic [1:0]        r_hidx;
  logic [31:0]       r_ip;
  logic [15:0]       r_sport;
  logic [15:0]       r_dport;
  logic [31:0]       r_acc;
  logic              r_trunc;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mem [DEPTH];

  logic              w_rdy;
  logic              w_accept;
  logic              w_first;
  logic              w_store;
  logic [15:0]       w_bidx;
  logic [1:0]        w_lane;
  logic              w_we;
  logic [AWIDTH-1:0] w_waddr;
  logic [31:0]       w_wdata;

  // r_live holds app_ready low for the reset cycle even though the FSM already sits in IDLE
  assign w_rdy     = r_live && ((r_state == IDLE) || (r_state == FILL));
  assign app_ready = w_rdy;
  assign w_accept  = app_valid && w_rdy;
  assign w_first   = (r_state == IDLE);
  assign w_store   = w_accept && (w_first || (r_cnt < MAXB));
  assign w_bidx    = w_first ? 16'd0 : r_cnt;
  assign w_lane    = w_bidx[1:0];

  assign tx_trunc        = r_trunc;
  assign udp_txbuf_rdata = r_rdata;

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    udp_txbuf_rel = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next = app_last ? HDR : FILL;
      FILL: if (w_accept && app_last) w_next = HDR;
      HDR:  if (r_hidx == 2'd2) w_next = REL;
      REL: begin
        udp_txbuf_rel = 1'b1;
        w_next        = BUSY;
      end
      BUSY: if (udp_txbuf_grant) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Single write port: header words in HDR, otherwise payload bytes merged into the current word
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = r_acc;
    if (r_state == HDR) begin
      w_we    = 1'b1;
      w_waddr = AWIDTH'(r_hidx);
      case (r_hidx)
        2'd0:    w_wdata = {r_ip[7:0], r_ip[15:8], r_ip[23:16], r_ip[31:24]};
        2'd1:    w_wdata = {r_sport, r_dport};
        default: w_wdata = {16'h0, r_cnt};
      endcase
    end else if (w_store) begin
      w_we    = 1'b1;
      w_waddr = AWIDTH'(w_bidx >> 2) + AWIDTH'(3);
      case (w_lane)
        2'd0:    w_wdata = {24'h0, app_data};
        2'd1:    w_wdata[15:8] = app_data;
        2'd2:    w_wdata[23:16] = app_data;
        default: w_wdata[31:24] = app_data;
      endcase
    end
  end

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      r_live  <= 1'b0;
      r_cnt   <= '0;
      r_trunc <= 1'b0;
      r_hidx  <= '0;
      r_ip    <= '0;
      r_sport <= '0;
      r_dport <= '0;
      r_acc   <= '0;
    end else begin
      r_live <= 1'b1;
      r_hidx <= (r_state == HDR) ? r_hidx + 2'd1 : 2'd0;
      if (w_store) r_acc <= w_wdata;
      if (w_accept) begin
        if (w_first) begin
          r_ip    <= app_dst_ip;
          r_sport <= app_src_port;
          r_dport <= app_dst_port;
          r_cnt   <= 16'd1;
          r_trunc <= 1'b0;
        end else if (r_cnt < MAXB) begin
          r_cnt <= r_cnt + 16'd1;
        end else begin
          r_trunc <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_int) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n)            r_rdata <= '0;
    else if (udp_txbuf_ce) r_rdata <= r_mem[udp_txbuf_addr];
  end

`ifdef UDP_TX_FRAMER_CNT_EN
  logic [15:0] r_frame_cnt;
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n)              r_frame_cnt <= '0;
    else if (r_state == REL) r_frame_cnt <= r_frame_cnt + 16'd1;
  end
  assign tx_frame_count = r_frame_cnt;
`else
  assign tx_frame_count = 16'h0;
`endif

endmodule

// File: tb/tb_udp_tx_framer.sv
// Randomized bench for udp_tx_framer against a byte-level model of the buffer image.
module tb_udp_tx_framer;
  localparam int AW   = 6;
  localparam int NW   = 1 << AW;
  localparam int MAXB = 4 * (NW - 3);

  logic          clk_int = 1'b0;
  logic          rst_n = 1'b0;
  logic          app_valid = 1'b0;
  logic          app_ready;
  logic [7:0]    app_data = '0;
  logic          app_last = 1'b0;
  logic [31:0]   app_dst_ip = '0;
  logic [15:0]   app_src_port = '0;
  logic [15:0]   app_dst_port = '0;
  logic          tx_trunc;
  logic          udp_txbuf_rel;
  logic          udp_txbuf_grant = 1'b0;
  logic [AW-1:0] udp_txbuf_addr = '0;
  logic          udp_txbuf_ce = 1'b0;
  logic [31:0]   udp_txbuf_rdata;
  logic [15:0]   tx_frame_count;

  int n_tests = 0;
  int n_fail = 0;
  int exp_frames = 0;
  byte unsigned q_bytes[$];
  logic [31:0] exp_words[NW];
  int exp_nwords;
  logic exp_trunc;

  always #5 clk_int = ~clk_int;

  udp_tx_framer #(.AWIDTH(AW)) dut (
    .clk_int(clk_int), .rst_n(rst_n),
    .app_valid(app_valid), .app_ready(app_ready), .app_data(app_data), .app_last(app_last),
    .app_dst_ip(app_dst_ip), .app_src_port(app_src_port), .app_dst_port(app_dst_port),
    .tx_trunc(tx_trunc), .udp_txbuf_rel(udp_txbuf_rel), .udp_txbuf_grant(udp_txbuf_grant),
    .udp_txbuf_addr(udp_txbuf_addr), .udp_txbuf_ce(udp_txbuf_ce),
    .udp_txbuf_rdata(udp_txbuf_rdata), .tx_frame_count(tx_frame_count)
  );

  function automatic logic [15:0] exp_count();
`ifdef UDP_TX_FRAMER_CNT_EN
    return 16'(exp_frames);
`else
    return 16'h0;
`endif
  endfunction

  // Expected buffer image from the datagram's bytes and header fields
  task automatic build_model(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp);
    int nb;
    logic [31:0] oct;
    nb = (q_bytes.size() > MAXB) ? MAXB : q_bytes.size();
    for (int i = 0; i < NW; i++) exp_words[i] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      oct = (ip >> (24 - 8 * k)) & 32'hff;
      exp_words[0] = exp_words[0] + (oct << (8 * k));
    end
    exp_words[1] = (32'(sp) << 16) + 32'(dp);
    exp_words[2] = 32'(nb);
    for (int i = 0; i < nb; i++)
      exp_words[3 + i / 4] = exp_words[3 + i / 4] | (32'(q_bytes[i]) << (8 * (i % 4)));
    exp_nwords = 3 + (nb + 3) / 4;
    exp_trunc = (q_bytes.size() > MAXB);
  endtask

  task automatic send_bytes(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                            input bit last_flag, input int gap_pct, output bit ok);
    bit acc;
    int t;
    ok = 1'b1;
    for (int i = 0; i < q_bytes.size(); i++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        @(negedge clk_int);
        app_valid = 1'b0;
      end
      t = 0;
      do begin
        @(negedge clk_int);
        app_valid    = 1'b1;
        app_data     = q_bytes[i];
        app_last     = last_flag && (i == q_bytes.size() - 1);
        app_dst_ip   = (i == 0) ? ip : $urandom;
        app_src_port = (i == 0) ? sp : 16'($urandom);
        app_dst_port = (i == 0) ? dp : 16'($urandom);
        acc = app_ready;
        @(posedge clk_int);
        t++;
      end while (!acc && t < 50);
      if (!acc) ok = 1'b0;
    end
    @(negedge clk_int);
    app_valid = 1'b0;
    app_last  = 1'b0;
  endtask

  task automatic wait_rel(output int pulses);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_int);
      if (udp_txbuf_rel) pulses++;
    end
  endtask

  task automatic read_word(input int a, output logic [31:0] d);
    @(negedge clk_int);
    udp_txbuf_ce   = 1'b1;
    udp_txbuf_addr = AW'(a);
    @(negedge clk_int);
    udp_txbuf_ce   = 1'b0;
    udp_txbuf_addr = AW'($urandom);
    d = udp_txbuf_rdata;
  endtask

  task automatic do_grant();
    @(negedge clk_int);
    udp_txbuf_grant = 1'b1;
    @(negedge clk_int);
    udp_txbuf_grant = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_int);
    n_tests++; if (app_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", app_ready); end
    n_tests++; if (udp_txbuf_rel !== 1'b0) begin n_fail++; $display("FAIL reset_rel got %b want 0", udp_txbuf_rel); end
    n_tests++; if (tx_trunc !== 1'b0) begin n_fail++; $display("FAIL reset_trunc got %b want 0", tx_trunc); end
    n_tests++; if (tx_frame_count !== 16'h0) begin n_fail++; $display("FAIL reset_count got %h want 0", tx_frame_count); end
    n_tests++; if (udp_txbuf_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", udp_txbuf_rdata); end
    @(negedge clk_int);
    rst_n = 1'b1;
    n_tests++; if (app_ready !== 1'b0) begin n_fail++; $display("FAIL release_ready_early got %b want 0", app_ready); end
    @(negedge clk_int);
    n_tests++; if (app_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b want 1", app_ready); end
  endtask

  task automatic test_spec_vector();
    string s;
    bit ok;
    int p;
    logic [31:0] d, held;
    s = "UDP Send Test\n";
    q_bytes.delete();
    for (int i = 0; i < s.len(); i++) q_bytes.push_back(s[i]);
    build_model(32'hc0a8010a, 16'd1111, 16'd1234);
    send_bytes(32'hc0a8010a, 16'd1111, 16'd1234, 1'b1, 25, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL spec_accept timeout got 0 want 1"); end
    wait_rel(p);
    exp_frames++;
    n_tests++; if (p != 1) begin n_fail++; $display("FAIL spec_rel_pulses got %0d want 1", p); end
    n_tests++; if (tx_frame_count !== exp_count()) begin n_fail++; $display("FAIL spec_count got %h want %h", tx_frame_count, exp_count()); end
    n_tests++; if (app_ready !== 1'b0) begin n_fail++; $display("FAIL spec_busy_ready got %b want 0", app_ready); end
    read_word(0, d);
    n_tests++; if (d !== 32'h0a01a8c0) begin n_fail++; $display("FAIL spec_word0 got %h want 0a01a8c0", d); end
    read_word(1, d);
    n_tests++; if (d !== 32'h045704d2) begin n_fail++; $display("FAIL spec_word1 got %h want 045704d2", d); end
    read_word(2, d);
    n_tests++; if (d !== 32'h0000000e) begin n_fail++; $display("FAIL spec_word2 got %h want 0000000e", d); end
    read_word(3, d);
    n_tests++; if (d !== 32'h20504455) begin n_fail++; $display("FAIL spec_word3 got %h want 20504455", d); end
    read_word(6, d);
    n_tests++; if (d !== 32'h00000a74) begin n_fail++; $display("FAIL spec_word6 got %h want 00000a74", d); end
    for (int a = 0; a < exp_nwords; a++) begin
      read_word(a, d);
      n_tests++; if (d !== exp_words[a]) begin n_fail++; $display("FAIL spec_image[%0d] got %h want %h", a, d, exp_words[a]); end
    end
    held = d;
    repeat (3) @(negedge clk_int);
    n_tests++; if (udp_txbuf_rdata !== held) begin n_fail++; $display("FAIL rdata_hold got %h want %h", udp_txbuf_rdata, held); end
    n_tests++; if (tx_trunc !== 1'b0) begin n_fail++; $display("FAIL spec_trunc got %b want 0", tx_trunc); end
    do_grant();
    n_tests++; if (app_ready !== 1'b1) begin n_fail++; $display("FAIL spec_after_grant got %b want 1", app_ready); end
  endtask

  task automatic test_single_byte();
    bit ok;
    int p;
    logic [31:0] d;
    q_bytes.delete();
    q_bytes.push_back(8'hab);
    send_bytes(32'h0a000001, 16'd7, 16'd9, 1'b1, 0, ok);
    wait_rel(p);
    exp_frames++;
    n_tests++; if (!ok || p != 1) begin n_fail++; $display("FAIL single_rel got ok=%0d pulses=%0d want ok=1 pulses=1", ok, p); end
    read_word(2, d);
    n_tests++; if (d !== 32'h00000001) begin n_fail++; $display("FAIL single_word2 got %h want 00000001", d); end
    read_word(3, d);
    n_tests++; if (d !== 32'h000000ab) begin n_fail++; $display("FAIL single_word3 got %h want 000000ab", d); end
    n_tests++; if (tx_trunc !== 1'b0) begin n_fail++; $display("FAIL single_trunc got %b want 0", tx_trunc); end
    do_grant();
  endtask

  task automatic test_truncation();
    bit ok;
    int p;
    logic [31:0] d;
    q_bytes.delete();
    for (int i = 0; i < 300; i++) q_bytes.push_back(8'($urandom));
    build_model(32'h01020304, 16'h1111, 16'h2222);
    send_bytes(32'h01020304, 16'h1111, 16'h2222, 1'b1, 0, ok);
    wait_rel(p);
    exp_frames++;
    n_tests++; if (!ok || p != 1) begin n_fail++; $display("FAIL trunc_rel got ok=%0d pulses=%0d want ok=1 pulses=1", ok, p); end
    n_tests++; if (tx_trunc !== 1'b1) begin n_fail++; $display("FAIL trunc_flag got %b want 1", tx_trunc); end
    read_word(2, d);
    n_tests++; if (d !== 32'h000000f4) begin n_fail++; $display("FAIL trunc_word2 got %h want 000000f4", d); end
    for (int a = 0; a < exp_nwords; a++) begin
      read_word(a, d);
      n_tests++; if (d !== exp_words[a]) begin n_fail++; $display("FAIL trunc_image[%0d] got %h want %h", a, d, exp_words[a]); end
    end
    do_grant();
    q_bytes.delete();
    for (int i = 0; i < 3; i++) q_bytes.push_back(8'($urandom));
    send_bytes(32'h05060708, 16'h1, 16'h2, 1'b1, 0, ok);
    n_tests++; if (tx_trunc !== 1'b0) begin n_fail++; $display("FAIL trunc_clear got %b want 0", tx_trunc); end
    wait_rel(p);
    exp_frames++;
    do_grant();
  endtask

  task automatic test_busy_backpressure();
    bit ok;
    int p, bad;
    logic [31:0] d;
    q_bytes.delete();
    for (int i = 0; i < 6; i++) q_bytes.push_back(8'($urandom));
    send_bytes(32'h11223344, 16'h10, 16'h20, 1'b1, 0, ok);
    wait_rel(p);
    exp_frames++;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_int);
      app_valid = 1'b1;
      app_data  = 8'hee;
      if (app_ready !== 1'b0) bad++;
    end
    @(negedge clk_int);
    app_valid = 1'b0;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL busy_ready got %0d ready cycles want 0", bad); end
    do_grant();
    n_tests++; if (app_ready !== 1'b1) begin n_fail++; $display("FAIL grant_ready got %b want 1", app_ready); end
    do_grant();
    n_tests++; if (app_ready !== 1'b1 || udp_txbuf_rel !== 1'b0) begin n_fail++; $display("FAIL idle_grant got ready=%b rel=%b want ready=1 rel=0", app_ready, udp_txbuf_rel); end
    q_bytes.delete();
    q_bytes.push_back(8'h5a);
    q_bytes.push_back(8'hc3);
    send_bytes(32'h0, 16'h0, 16'h0, 1'b1, 0, ok);
    wait_rel(p);
    exp_frames++;
    n_tests++; if (p != 1) begin n_fail++; $display("FAIL idle_grant_next_rel got %0d want 1", p); end
    read_word(3, d);
    n_tests++; if (d !== 32'h0000c35a) begin n_fail++; $display("FAIL idle_grant_word3 got %h want 0000c35a", d); end
    do_grant();
  endtask

  task automatic test_reset_mid_fill();
    bit ok;
    int p;
    logic [31:0] d;
    q_bytes.delete();
    for (int i = 0; i < 5; i++) q_bytes.push_back(8'($urandom));
    send_bytes(32'h0a0b0c0d, 16'h3, 16'h4, 1'b0, 0, ok);
    rst_n = 1'b0;
    exp_frames = 0;
    @(negedge clk_int);
    n_tests++; if (tx_frame_count !== 16'h0 || app_ready !== 1'b0) begin n_fail++; $display("FAIL midfill_reset got count=%h ready=%b want 0/0", tx_frame_count, app_ready); end
    rst_n = 1'b1;
    wait_rel(p);
    n_tests++; if (p != 0) begin n_fail++; $display("FAIL midfill_no_rel got %0d want 0", p); end
    q_bytes.delete();
    for (int i = 0; i < 4; i++) q_bytes.push_back(8'(8'h10 + i));
    send_bytes(32'h0a0b0c0d, 16'h3, 16'h4, 1'b1, 0, ok);
    wait_rel(p);
    exp_frames++;
    n_tests++; if (!ok || p != 1) begin n_fail++; $display("FAIL midfill_next_rel got ok=%0d pulses=%0d want 1/1", ok, p); end
    read_word(2, d);
    n_tests++; if (d !== 32'h00000004) begin n_fail++; $display("FAIL midfill_word2 got %h want 00000004", d); end
    read_word(3, d);
    n_tests++; if (d !== 32'h13121110) begin n_fail++; $display("FAIL midfill_word3 got %h want 13121110", d); end
    n_tests++; if (tx_frame_count !== exp_count()) begin n_fail++; $display("FAIL midfill_count got %h want %h", tx_frame_count, exp_count()); end
    do_grant();
  endtask

  task automatic test_random();
    bit ok;
    int p, len;
    logic [31:0] d, ip;
    logic [15:0] sp, dp;
    for (int n = 0; n < 6; n++) begin
      len = $urandom_range(1, 280);
      ip = $urandom;
      sp = 16'($urandom);
      dp = 16'($urandom);
      q_bytes.delete();
      for (int i = 0; i < len; i++) q_bytes.push_back(8'($urandom));
      build_model(ip, sp, dp);
      send_bytes(ip, sp, dp, 1'b1, 30, ok);
      wait_rel(p);
      exp_frames++;
      n_tests++; if (!ok || p != 1) begin n_fail++; $display("FAIL rand%0d_rel got ok=%0d pulses=%0d want 1/1", n, ok, p); end
      n_tests++; if (tx_trunc !== exp_trunc) begin n_fail++; $display("FAIL rand%0d_trunc got %b want %b", n, tx_trunc, exp_trunc); end
      n_tests++; if (tx_frame_count !== exp_count()) begin n_fail++; $display("FAIL rand%0d_count got %h want %h", n, tx_frame_count, exp_count()); end
      for (int a = 0; a < exp_nwords; a++) begin
        read_word(a, d);
        n_tests++; if (d !== exp_words[a]) begin n_fail++; $display("FAIL rand%0d_image[%0d] got %h want %h", n, a, d, exp_words[a]); end
      end
      repeat ($urandom_range(0, 4)) @(negedge clk_int);
      do_grant();
    end
  endtask

  initial begin
    test_reset();
    test_spec_vector();
    test_single_byte();
    test_truncation();
    test_busy_backpressure();
    test_reset_mid_fill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
